// File: rtl/mem_ring_pkg.sv
// Shared definitions for the circulating memory request ring.
// Used by the ring requester and by the memory controller.
//   PKT_*       : ring packet type codes
//   ID_W        : transaction ID width
//   ADDR_W      : line address width
//   OUTS_W      : width of the outstanding-transaction count
//   ring_hdr_t  : slot header (type, id, addr); the payload is carried
//                 separately because its width is a per-instance parameter
package mem_ring_pkg;

   localparam int ID_W   = 4;
   localparam int ADDR_W = 36;
   localparam int OUTS_W = 5;

   localparam logic [2:0] PKT_EMPTY   = 3'b000;
   localparam logic [2:0] PKT_WR      = 3'b001;
   localparam logic [2:0] PKT_RD      = 3'b011;
   localparam logic [2:0] PKT_WR_ACK  = 3'b101;
   localparam logic [2:0] PKT_RD_DATA = 3'b110;

   typedef struct packed {
      logic [2:0]        ptype;
      logic [ID_W-1:0]   id;
      logic [ADDR_W-1:0] addr;
   } ring_hdr_t;

   function automatic logic is_resp(input logic [2:0] ptype);
      return (ptype == PKT_WR_ACK) || (ptype == PKT_RD_DATA);
   endfunction

endpackage

// File: rtl/mem_ring_id_table.sv
// Transaction ID table for the ring requester.
// Holds busy/write/addr per owned ID (indexed relative to the ID base),
// finds the lowest free index, and answers lookups by index.
//   clk, rst                    : clock, synchronous active-high reset
//   set_en/set_idx/set_write/set_addr : allocate an entry
//   clr_en/clr_idx              : free an entry
//   look_idx -> look_busy/look_write/look_addr : lookup
//   free_valid/free_idx         : lowest free entry (from registered state,
//                                 so an entry freed this cycle is not offered)
//   outstanding                 : number of busy entries
module mem_ring_id_table
   import mem_ring_pkg::*;
#(
   parameter int NUM_IDS = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              set_en,
   input  logic [ID_W-1:0]   set_idx,
   input  logic              set_write,
   input  logic [ADDR_W-1:0] set_addr,
   input  logic              clr_en,
   input  logic [ID_W-1:0]   clr_idx,
   input  logic [ID_W-1:0]   look_idx,
   output logic              look_busy,
   output logic              look_write,
   output logic [ADDR_W-1:0] look_addr,
   output logic              free_valid,
   output logic [ID_W-1:0]   free_idx,
   output logic [OUTS_W-1:0] outstanding
);

   logic [NUM_IDS-1:0] busy_q, busy_d;
   logic [NUM_IDS-1:0] write_q, write_d;
   logic [ADDR_W-1:0]  addr_q [NUM_IDS];
   logic [ADDR_W-1:0]  addr_d [NUM_IDS];
   logic [OUTS_W-1:0]  cnt_q, cnt_d;

   always_comb begin
      busy_d  = busy_q;
      write_d = write_q;
      addr_d  = addr_q;
      for (int i = 0; i < NUM_IDS; i++) begin
         if (clr_en && (clr_idx == ID_W'(i))) begin
            busy_d[i] = 1'b0;
         end
         if (set_en && (set_idx == ID_W'(i))) begin
            busy_d[i]  = 1'b1;
            write_d[i] = set_write;
            addr_d[i]  = set_addr;
         end
      end
      // set and clear in the same cycle cancel out
      cnt_d = cnt_q;
      case ({set_en, clr_en})
         2'b10:   cnt_d = cnt_q + OUTS_W'(1);
         2'b01:   cnt_d = cnt_q - OUTS_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_comb begin
      look_busy  = 1'b0;
      look_write = 1'b0;
      look_addr  = '0;
      for (int i = 0; i < NUM_IDS; i++) begin
         if (look_idx == ID_W'(i)) begin
            look_busy  = busy_q[i];
            look_write = write_q[i];
            look_addr  = addr_q[i];
         end
      end
   end

   // scan downward so the lowest free index is the last one written
   always_comb begin
      free_valid = 1'b0;
      free_idx   = '0;
      for (int i = NUM_IDS - 1; i >= 0; i--) begin
         if (!busy_q[i]) begin
            free_valid = 1'b1;
            free_idx   = ID_W'(i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q  <= '0;
         write_q <= '0;
         cnt_q   <= '0;
         for (int i = 0; i < NUM_IDS; i++) begin
            addr_q[i] <= '0;
         end
      end else begin
         busy_q  <= busy_d;
         write_q <= write_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign outstanding = cnt_q;

endmodule

// File: rtl/mem_ring_requester.sv
// Ring-side initiator for the memory controller.
// Takes one client request at a time, injects it into an empty ring slot
// under an owned transaction ID, and pulls the matching response back off
// the ring for the client. Other traffic passes through one register stage.
//   clk, rst                       : clock, synchronous active-high reset
//   req_valid/req_ready/req_write/req_addr/req_data : client request
//   resp_valid/resp_ready/resp_write/resp_addr/resp_data/resp_id : response
//   *_in / *_out                   : incoming / outgoing ring slot
//   outstanding                    : number of busy IDs
module mem_ring_requester
   import mem_ring_pkg::*;
#(
   parameter int DEPTH   = 512,
   parameter int ID_BASE = 0,
   parameter int NUM_IDS = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DEPTH-1:0]  req_data,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic              resp_write,
   output logic [ADDR_W-1:0] resp_addr,
   output logic [DEPTH-1:0]  resp_data,
   output logic [ID_W-1:0]   resp_id,
   input  logic [2:0]        packet_type_req_in,
   input  logic [ID_W-1:0]   id_req_in,
   input  logic [ADDR_W-1:0] addr_in,
   input  logic [DEPTH-1:0]  data_in,
   output logic [2:0]        packet_type_req_out,
   output logic [ID_W-1:0]   id_req_out,
   output logic [ADDR_W-1:0] addr_out,
   output logic [DEPTH-1:0]  data_out,
   output logic [OUTS_W-1:0] outstanding
);

   logic              pend_valid_q, pend_valid_d;
   logic              pend_write_q, pend_write_d;
   logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
   logic [DEPTH-1:0]  pend_data_q, pend_data_d;

   logic              resp_valid_q, resp_valid_d;
   logic              resp_write_q, resp_write_d;
   logic [ADDR_W-1:0] resp_addr_q, resp_addr_d;
   logic [DEPTH-1:0]  resp_data_q, resp_data_d;
   logic [ID_W-1:0]   resp_id_q, resp_id_d;

   ring_hdr_t         out_hdr_q, out_hdr_d;
   logic [DEPTH-1:0]  out_data_q, out_data_d;

   logic [ID_W:0]     in_rel;
   logic [ID_W-1:0]   in_idx;
   logic              in_range;
   logic              look_busy, look_write;
   logic [ADDR_W-1:0] look_addr;
   logic              free_valid;
   logic [ID_W-1:0]   free_idx;
   logic              consume, inject;

   // One extra bit: an ID below the base wraps to >= 16, which is never
   // below NUM_IDS, so a single compare covers both ends of the range.
   assign in_rel   = {1'b0, id_req_in} - (ID_W+1)'(ID_BASE);
   assign in_range = in_rel < (ID_W+1)'(NUM_IDS);
   assign in_idx   = in_rel[ID_W-1:0];

   mem_ring_id_table #(
      .NUM_IDS (NUM_IDS)
   ) u_id_table (
      .clk         (clk),
      .rst         (rst),
      .set_en      (inject),
      .set_idx     (free_idx),
      .set_write   (pend_write_q),
      .set_addr    (pend_addr_q),
      .clr_en      (consume),
      .clr_idx     (in_idx),
      .look_idx    (in_idx),
      .look_busy   (look_busy),
      .look_write  (look_write),
      .look_addr   (look_addr),
      .free_valid  (free_valid),
      .free_idx    (free_idx),
      .outstanding (outstanding)
   );

   always_comb begin
      // a response we cannot hold yet stays on the ring for another lap
      consume = is_resp(packet_type_req_in) && in_range && look_busy &&
                (!resp_valid_q || resp_ready);
      inject  = ((packet_type_req_in == PKT_EMPTY) || consume) &&
                pend_valid_q && free_valid;

      out_hdr_d.ptype = packet_type_req_in;
      out_hdr_d.id    = id_req_in;
      out_hdr_d.addr  = addr_in;
      out_data_d      = data_in;
      if (inject) begin
         out_hdr_d.ptype = pend_write_q ? PKT_WR : PKT_RD;
         out_hdr_d.id    = ID_W'(ID_BASE) + free_idx;
         out_hdr_d.addr  = pend_addr_q;
         out_data_d      = pend_write_q ? pend_data_q : '0;
      end else if (consume) begin
         out_hdr_d  = '0;
         out_data_d = '0;
      end

      resp_valid_d = resp_valid_q;
      resp_write_d = resp_write_q;
      resp_addr_d  = resp_addr_q;
      resp_data_d  = resp_data_q;
      resp_id_d    = resp_id_q;
      if (consume) begin
         // report the recorded direction even if the packet type disagrees
         resp_valid_d = 1'b1;
         resp_write_d = look_write;
         resp_addr_d  = look_addr;
         resp_data_d  = (packet_type_req_in == PKT_RD_DATA) ? data_in : '0;
         resp_id_d    = id_req_in;
      end else if (resp_ready) begin
         resp_valid_d = 1'b0;
      end

      pend_valid_d = pend_valid_q;
      pend_write_d = pend_write_q;
      pend_addr_d  = pend_addr_q;
      pend_data_d  = pend_data_q;
      if (req_valid && !pend_valid_q) begin
         pend_valid_d = 1'b1;
         pend_write_d = req_write;
         pend_addr_d  = req_addr;
         pend_data_d  = req_data;
      end else if (inject) begin
         pend_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pend_valid_q <= 1'b0;
         pend_write_q <= 1'b0;
         pend_addr_q  <= '0;
         pend_data_q  <= '0;
         resp_valid_q <= 1'b0;
         resp_write_q <= 1'b0;
         resp_addr_q  <= '0;
         resp_data_q  <= '0;
         resp_id_q    <= '0;
         out_hdr_q    <= '0;
         out_data_q   <= '0;
      end else begin
         pend_valid_q <= pend_valid_d;
         pend_write_q <= pend_write_d;
         pend_addr_q  <= pend_addr_d;
         pend_data_q  <= pend_data_d;
         resp_valid_q <= resp_valid_d;
         resp_write_q <= resp_write_d;
         resp_addr_q  <= resp_addr_d;
         resp_data_q  <= resp_data_d;
         resp_id_q    <= resp_id_d;
         out_hdr_q    <= out_hdr_d;
         out_data_q   <= out_data_d;
      end
   end

   assign req_ready           = ~pend_valid_q;
   assign resp_valid          = resp_valid_q;
   assign resp_write          = resp_write_q;
   assign resp_addr           = resp_addr_q;
   assign resp_data           = resp_data_q;
   assign resp_id             = resp_id_q;
   assign packet_type_req_out = out_hdr_q.ptype;
   assign id_req_out          = out_hdr_q.id;
   assign addr_out            = out_hdr_q.addr;
   assign data_out            = out_data_q;

endmodule

// File: tb/tb_mem_ring_requester.sv
module tb_mem_ring_requester;
   import mem_ring_pkg::*;

   localparam int DEPTH   = 64;
   localparam int ID_BASE = 4;
   localparam int NUM_IDS = 4;

   typedef struct packed {
      logic [2:0]       ptype;
      logic [3:0]       id;
      logic [35:0]      addr;
      logic [DEPTH-1:0] data;
   } pkt_t;

   typedef struct packed {
      logic             w;
      logic [35:0]      addr;
      logic [DEPTH-1:0] data;
      logic [3:0]       id;
   } rsp_t;

   typedef struct {
      pkt_t in;
      pkt_t exp;
   } vec_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             req_valid, req_ready, req_write;
   logic [35:0]      req_addr;
   logic [DEPTH-1:0] req_data;
   logic             resp_valid, resp_ready, resp_write;
   logic [35:0]      resp_addr;
   logic [DEPTH-1:0] resp_data;
   logic [3:0]       resp_id;
   logic [2:0]       packet_type_req_in, packet_type_req_out;
   logic [3:0]       id_req_in, id_req_out;
   logic [35:0]      addr_in, addr_out;
   logic [DEPTH-1:0] data_in, data_out;
   logic [4:0]       outstanding;

   int   n_vec = 0;
   int   n_err = 0;
   pkt_t exp_q[$];
   rsp_t rsp_q[$];
   rsp_t mon_r;

   localparam pkt_t EMPTY = '0;

   mem_ring_requester #(
      .DEPTH(DEPTH), .ID_BASE(ID_BASE), .NUM_IDS(NUM_IDS)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_data(req_data),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_write(resp_write),
      .resp_addr(resp_addr), .resp_data(resp_data), .resp_id(resp_id),
      .packet_type_req_in(packet_type_req_in), .id_req_in(id_req_in),
      .addr_in(addr_in), .data_in(data_in),
      .packet_type_req_out(packet_type_req_out), .id_req_out(id_req_out),
      .addr_out(addr_out), .data_out(data_out),
      .outstanding(outstanding)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic pkt_t pk(input logic [2:0] t, input logic [3:0] id,
                               input logic [35:0] a, input logic [63:0] d);
      pkt_t p;
      p.ptype = t; p.id = id; p.addr = a; p.data = d;
      return p;
   endfunction

   function automatic rsp_t rs(input logic w, input logic [35:0] a,
                               input logic [63:0] d, input logic [3:0] id);
      rsp_t r;
      r.w = w; r.addr = a; r.data = d; r.id = id;
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic ring_cycle(input pkt_t in, input pkt_t exp);
      pkt_t e;
      packet_type_req_in = in.ptype;
      id_req_in          = in.id;
      addr_in            = in.addr;
      data_in            = in.data;
      exp_q.push_back(exp);
      step();
      e = exp_q.pop_front();
      chk("out_type", 64'(packet_type_req_out), 64'(e.ptype));
      chk("out_id",   64'(id_req_out),          64'(e.id));
      chk("out_addr", 64'(addr_out),            64'(e.addr));
      chk("out_data", data_out,                 e.data);
   endtask

   task automatic issue(input logic wr, input logic [35:0] a,
                        input logic [63:0] d, input logic [3:0] id);
      req_valid = 1'b1; req_write = wr; req_addr = a; req_data = d;
      ring_cycle(EMPTY, EMPTY);
      chk("req_ready_after_accept", 64'(req_ready), 64'd0);
      req_valid = 1'b0;
      ring_cycle(EMPTY, pk(wr ? PKT_WR : PKT_RD, id, a, wr ? d : 64'd0));
   endtask

   // response scoreboard: compare when the client actually takes it
   always @(negedge clk) begin
      if (rst === 1'b0 && resp_valid === 1'b1) begin
         if (rsp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL resp_unexpected: got resp id %0h expected no response", resp_id);
         end else if (resp_ready) begin
            mon_r = rsp_q.pop_front();
            chk("resp_write", 64'(resp_write), 64'(mon_r.w));
            chk("resp_addr",  64'(resp_addr),  64'(mon_r.addr));
            chk("resp_data",  resp_data,       mon_r.data);
            chk("resp_id",    64'(resp_id),    64'(mon_r.id));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[8];
      vecs[0] = '{pk(3'b110, 4'd1, 36'h123, 64'h55),        pk(3'b110, 4'd1, 36'h123, 64'h55)};
      vecs[1] = '{pk(3'b011, 4'd9, 36'hABC, 64'h66),        pk(3'b011, 4'd9, 36'hABC, 64'h66)};
      vecs[2] = '{pk(3'b101, 4'd8, 36'h1, 64'h7),           pk(3'b101, 4'd8, 36'h1, 64'h7)};
      vecs[3] = '{pk(3'b110, 4'd3, 36'h2, 64'h8),           pk(3'b110, 4'd3, 36'h2, 64'h8)};
      vecs[4] = '{pk(3'b101, 4'd5, 36'h3, 64'h9),           pk(3'b101, 4'd5, 36'h3, 64'h9)};
      vecs[5] = '{pk(3'b111, 4'd6, 36'hF_0000_0001, 64'hA), pk(3'b111, 4'd6, 36'hF_0000_0001, 64'hA)};
      vecs[6] = '{pk(3'b000, 4'd0, 36'h999, 64'h1),         pk(3'b000, 4'd0, 36'h999, 64'h1)};
      vecs[7] = '{pk(3'b010, 4'd7, 36'h444, 64'hFFFF),      pk(3'b010, 4'd7, 36'h444, 64'hFFFF)};

      rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_data = '0;
      resp_ready = 1'b1;
      packet_type_req_in = 3'b111; id_req_in = 4'd5; addr_in = 36'h77; data_in = 64'h77;
      step(); step();
      chk("rst_req_ready",  64'(req_ready),  64'd1);
      chk("rst_resp_valid", 64'(resp_valid), 64'd0);
      chk("rst_resp_write", 64'(resp_write), 64'd0);
      chk("rst_resp_addr",  64'(resp_addr),  64'd0);
      chk("rst_resp_data",  resp_data,       64'd0);
      chk("rst_resp_id",    64'(resp_id),    64'd0);
      chk("rst_out_type",   64'(packet_type_req_out), 64'd0);
      chk("rst_out_data",   data_out,        64'd0);
      chk("rst_outstanding", 64'(outstanding), 64'd0);
      rst = 1'b0;

      // foreign and non-matching traffic passes unchanged
      for (int i = 0; i < 8; i++) begin
         ring_cycle(vecs[i].in, vecs[i].exp);
         chk("foreign_no_resp", 64'(resp_valid), 64'd0);
      end

      // read round trip
      issue(1'b0, 36'h0_0000_0040, 64'd0, 4'd4);
      chk("rd_outstanding", 64'(outstanding), 64'd1);
      rsp_q.push_back(rs(1'b0, 36'h40, 64'hA5A5_A5A5_A5A5_A5A5, 4'd4));
      ring_cycle(pk(PKT_RD_DATA, 4'd4, 36'd0, 64'hA5A5_A5A5_A5A5_A5A5), EMPTY);
      chk("rd_resp_valid", 64'(resp_valid), 64'd1);
      chk("rd_outstanding_after", 64'(outstanding), 64'd0);
      ring_cycle(EMPTY, EMPTY);
      chk("rd_resp_dropped", 64'(resp_valid), 64'd0);

      // write round trip; ack payload must not leak into resp_data
      issue(1'b1, 36'h80, 64'h1234, 4'd4);
      rsp_q.push_back(rs(1'b1, 36'h80, 64'd0, 4'd4));
      ring_cycle(pk(PKT_WR_ACK, 4'd4, 36'd0, 64'hDEAD), EMPTY);
      ring_cycle(EMPTY, EMPTY);

      // ID exhaustion
      for (int i = 0; i < 4; i++) begin
         issue(1'b0, 36'h100 + 36'(i), 64'd0, 4'(4 + i));
      end
      chk("exh_outstanding", 64'(outstanding), 64'd4);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 36'h200;
      ring_cycle(EMPTY, EMPTY);
      req_valid = 1'b0;
      ring_cycle(EMPTY, EMPTY);
      ring_cycle(EMPTY, EMPTY);
      chk("exh_req_ready", 64'(req_ready), 64'd0);
      chk("exh_outstanding_hold", 64'(outstanding), 64'd4);
      rsp_q.push_back(rs(1'b0, 36'h102, 64'h6666, 4'd6));
      ring_cycle(pk(PKT_RD_DATA, 4'd6, 36'd0, 64'h6666), EMPTY);
      ring_cycle(EMPTY, pk(PKT_RD, 4'd6, 36'h200, 64'd0));
      chk("exh_outstanding_reuse", 64'(outstanding), 64'd4);
      chk("exh_req_ready_after", 64'(req_ready), 64'd1);
      rsp_q.push_back(rs(1'b0, 36'h100, 64'h4444, 4'd4));
      ring_cycle(pk(PKT_RD_DATA, 4'd4, 36'd0, 64'h4444), EMPTY);
      rsp_q.push_back(rs(1'b0, 36'h101, 64'h5555, 4'd5));
      ring_cycle(pk(PKT_RD_DATA, 4'd5, 36'd0, 64'h5555), EMPTY);
      rsp_q.push_back(rs(1'b0, 36'h103, 64'h7777, 4'd7));
      ring_cycle(pk(PKT_RD_DATA, 4'd7, 36'd0, 64'h7777), EMPTY);
      rsp_q.push_back(rs(1'b0, 36'h200, 64'h2222, 4'd6));
      ring_cycle(pk(PKT_RD_DATA, 4'd6, 36'd0, 64'h2222), EMPTY);
      ring_cycle(EMPTY, EMPTY);
      chk("exh_drained", 64'(outstanding), 64'd0);

      // backpressure: second match stays on the ring
      issue(1'b0, 36'h300, 64'd0, 4'd4);
      issue(1'b0, 36'h304, 64'd0, 4'd5);
      resp_ready = 1'b0;
      rsp_q.push_back(rs(1'b0, 36'h300, 64'hD1, 4'd4));
      ring_cycle(pk(PKT_RD_DATA, 4'd4, 36'd0, 64'hD1), EMPTY);
      ring_cycle(pk(PKT_RD_DATA, 4'd5, 36'd0, 64'hD2), pk(PKT_RD_DATA, 4'd5, 36'd0, 64'hD2));
      chk("bp_outstanding", 64'(outstanding), 64'd1);
      chk("bp_resp_valid_hold", 64'(resp_valid), 64'd1);
      chk("bp_resp_addr_hold",  64'(resp_addr),  64'h300);
      chk("bp_resp_data_hold",  resp_data,       64'hD1);
      resp_ready = 1'b1;
      ring_cycle(EMPTY, EMPTY);
      rsp_q.push_back(rs(1'b0, 36'h304, 64'hD2, 4'd5));
      ring_cycle(pk(PKT_RD_DATA, 4'd5, 36'd0, 64'hD2), EMPTY);
      ring_cycle(EMPTY, EMPTY);
      chk("bp_outstanding_after", 64'(outstanding), 64'd0);

      // consume + inject in one slot; ack on a read entry reports read
      issue(1'b0, 36'h400, 64'd0, 4'd4);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 36'h440;
      ring_cycle(EMPTY, EMPTY);
      req_valid = 1'b0;
      rsp_q.push_back(rs(1'b0, 36'h400, 64'd0, 4'd4));
      ring_cycle(pk(PKT_WR_ACK, 4'd4, 36'd0, 64'hFFFF), pk(PKT_RD, 4'd5, 36'h440, 64'd0));
      chk("ci_outstanding", 64'(outstanding), 64'd1);
      chk("ci_resp_write_recorded", 64'(resp_write), 64'd0);
      rsp_q.push_back(rs(1'b0, 36'h440, 64'hCAFE, 4'd5));
      ring_cycle(pk(PKT_RD_DATA, 4'd5, 36'd0, 64'hCAFE), EMPTY);
      ring_cycle(EMPTY, EMPTY);

      // reset mid-operation with a pending request
      issue(1'b0, 36'h500, 64'd0, 4'd4);
      issue(1'b1, 36'h504, 64'hBEEF, 4'd5);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 36'h508;
      ring_cycle(EMPTY, EMPTY);
      chk("mid_outstanding", 64'(outstanding), 64'd2);
      req_valid = 1'b0;
      rst = 1'b1;
      packet_type_req_in = PKT_RD_DATA; id_req_in = 4'd4; addr_in = 36'h1; data_in = 64'h1;
      step();
      chk("mid_rst_outstanding", 64'(outstanding), 64'd0);
      chk("mid_rst_out_type",    64'(packet_type_req_out), 64'd0);
      chk("mid_rst_out_id",      64'(id_req_out), 64'd0);
      chk("mid_rst_out_addr",    64'(addr_out), 64'd0);
      chk("mid_rst_out_data",    data_out, 64'd0);
      chk("mid_rst_req_ready",   64'(req_ready), 64'd1);
      chk("mid_rst_resp_valid",  64'(resp_valid), 64'd0);
      rst = 1'b0;
      ring_cycle(pk(PKT_RD_DATA, 4'd4, 36'd0, 64'h99), pk(PKT_RD_DATA, 4'd4, 36'd0, 64'h99));
      ring_cycle(EMPTY, EMPTY);
      chk("mid_no_resp", 64'(resp_valid), 64'd0);

      chk("resp_queue_empty", 64'(rsp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mem_ring_requester.md
# mem_ring_requester

Ring-side initiator for the memory controller on the circulating request ring. Accepts one cache/core memory request at a time, allocates a transaction ID from its owned ID range, injects a read (011) or write (001) packet into an empty ring slot, then removes the matching read-data (110) or write-ack (101) response and presents it to the local client. Packets not addressed to this node pass through one register stage unchanged.

## Interface
- `DEPTH`, 512: ring payload width in bits.
- `ID_BASE`, 0: first transaction ID this node owns.
- `NUM_IDS`, 4: number of IDs owned, 1..16. `ID_BASE+NUM_IDS` must be ≤16.

Ports:
- `clk` in 1: the block's single clock.
- `rst` in 1: reset, synchronous and active-high.
- `req_valid` in 1: client request valid.
- `req_ready` out 1: request accepted on the cycle `req_valid & req_ready`.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in 36: line address.
- `req_data` in DEPTH: write data.
- `resp_valid` out 1: response valid.
- `resp_ready` in 1: client takes the response.
- `resp_write` out 1: 1 = write ack, 0 = read data.
- `resp_addr` out 36: address recorded when the request was issued.
- `resp_data` out DEPTH: read data. Zero for a write ack.
- `resp_id` out 4: transaction ID.
- `packet_type_req_in` in 3, `id_req_in` in 4, `addr_in` in 36, `data_in` in DEPTH: incoming ring slot.
- `packet_type_req_out` out 3, `id_req_out` out 4, `addr_out` out 36, `data_out` out DEPTH: outgoing ring slot.
- `outstanding` out 5: number of busy IDs.

## Operation
- Packet types:
  - 000: empty.
  - 001: write request.
  - 011: read request.
  - 101: write ack.
  - 110: read data.
  - Any other code: passes through.
- **Pending register**, one entry.
  - `req_ready = ~pend_valid`.
  - On accept, the register captures `req_write`, `req_addr` and `req_data`.
- **ID table**, NUM_IDS entries. Each entry holds `busy`, `write` and `addr`.
  - Allocation takes the lowest free index `k` and issues ID `ID_BASE+k`.
- **Response match**:
  - The incoming type is 101 or 110.
  - `id_req_in` lies in [ID_BASE, ID_BASE+NUM_IDS).
  - The entry for that ID is busy.
  - `resp_valid` is 0, or `resp_ready` is 1 this cycle.
- **On a match (consume)**:
  - Load the response register: `resp_write` = table write bit, `resp_addr` = table addr, `resp_data` = `data_in` for 110 or 0 for 101, `resp_id` = `id_req_in`.
  - Clear the entry's `busy` bit.
  - The slot becomes empty: type 000, id/addr/data 0.
- **Match on everything except the resp-free condition**: the packet passes unchanged and comes back on a later lap.
- **Type mismatch** (for example 101 on an entry recorded as a read): consume anyway and report the recorded `write` bit.
- **Inject** when all of the following hold:
  - the effective slot is empty, meaning the incoming type is 000 or it was just consumed;
  - `pend_valid` is 1;
  - at least one ID is free.
- **On inject**:
  - `packet_type_req_out` = 001 or 011, `id_req_out` = allocated ID, `addr_out` = pending addr, `data_out` = pending data for a write or 0 for a read.
  - Mark the entry busy and record write/addr.
  - Clear `pend_valid`.
- **Same-cycle cases**:
  - Consume plus inject in the same slot is required.
  - The ID freed this cycle cannot be reallocated until the next cycle.
- **Otherwise**: copy the incoming slot to the outgoing slot.
- **All IDs busy**: the pending request waits, `req_ready` stays 0, and pass-through continues.
- **Arithmetic**: `outstanding` counts busy entries and goes up or down by 1 per event. When inject and consume happen in the same cycle it is unchanged.

## Timing
- The ring path is one registered stage: outgoing slot at cycle n+1 = function of the incoming slot at cycle n.
- Request accept to earliest inject on `*_out` is 2 cycles (capture, then slot register), provided the slot is empty.
- A matching response to `resp_valid` high is 1 cycle.
- `resp_valid` holds, with the response fields stable, until `resp_ready`.
- `resp_ready` with a new match in the same cycle gives back-to-back responses.
- Reset values:
  - All `*_out` fields 0.
  - `req_ready` = 1.
  - `resp_valid` = 0, with `resp_write`, `resp_addr`, `resp_data` and `resp_id` all 0.
  - `outstanding` = 0.
  - Table and pending register cleared.
- Reset mid-transaction discards everything.
  - Later responses for the discarded IDs find non-busy entries and pass through.
  - The ring is flushed system-wide, so this does not matter.

## Structure
- `mem_ring_pkg` holds:
  - packet-type localparams PKT_EMPTY=3'b000, PKT_WR=3'b001, PKT_RD=3'b011, PKT_WR_ACK=3'b101, PKT_RD_DATA=3'b110;
  - the ring slot struct typedef;
  - the ID width constant.
  The memory controller shares this package.
- One sub-module, `mem_ring_id_table`, holds:
  - the busy, write and addr arrays;
  - the lowest-free priority encoder;
  - lookup by ID;
  - set and clear ports;
  - the outstanding count.

## Test plan
- **Read round trip**: reset, then a read at addr 0x0_0000_0040 with an all-000 ring.
  - Cycle 2: out = 011/id 0/addr 0x40.
  - Then drive 110/id 0/data 0xA5.. → `resp_valid` with `resp_write`=0, data 0xA5.., `resp_addr` 0x40; out slot 000.
- **Write**: write data 0x1234 to 0x80.
  - Inject 001/id 0/data 0x1234.
  - 101/id 0 → `resp_write`=1, `resp_data`=0.
- **ID exhaustion**: NUM_IDS=4.
  - Four requests get ids 0-3 and `outstanding`=4; a fifth holds with `req_ready`=0.
  - 110/id 2 → fifth injects with id 2 the next cycle.
- **Foreign traffic**: with ID_BASE=4, inputs 110/id 1 and 011/id 9 → emerge unchanged after 1 cycle; no response.
- **Backpressure**: `resp_ready`=0 with `resp_valid` set.
  - A second match passes through unchanged and its entry stays busy.
  - It is consumed on a later lap after `resp_ready`.
- **Consume+inject**: pending read while 101/id 0 arrives → same cycle consumed and replaced by 011 with id 1; `outstanding` unchanged.
- **Reset mid-op**: `rst` asserted with 2 outstanding → next cycle all outputs 0 and `outstanding` 0.
